posit_dot_sequencer: RTL and testbench

//  Sequences the shared combinational 8-bit posit MAC (es=0) through an N-term dot product.

---
 rtl/posit_pkg.sv | 7 +
 rtl/posit_mac_8bit.sv | 56 +++++
 rtl/posit_dot_sequencer.sv | 64 ++++++
 tb/tb_posit_dot_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// posit_pkg: shared posit constants and sequencer state encoding
package posit_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [7:0] POSIT_NAR  = 8'h80;
    localparam logic [7:0] POSIT_ZERO = 8'h00;
    localparam logic [7:0] POSIT_ONE  = 8'h40;
endpackage

// File: rtl/posit_mac_8bit.sv
// posit_mac_8bit: fused 8-bit posit (es=0) a*b+c, single round-to-nearest-even, saturating
module posit_mac_8bit
    import posit_pkg::*;
(
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic [7:0] in_c,
    output logic [7:0] res
);
    // Unpack into {sign, 4-bit signed regime scale, 6-bit significand 1.fffff}; zero yields significand 0
    function automatic logic [10:0] dec(input logic [7:0] p);
        logic [7:0] m;
        logic [6:0] t;
        int r;
        int k;
        m = p[7] ? -p : p;
        r = 1;
        for (int i = 5; i >= 0; i--) if (m[i] == m[6] && r == 6 - i) r++;
        k = m[6] ? r - 1 : -r;
        t = m[6:0] << (r + 1);
        return {p[7], 4'(k), (p == 8'h00) ? 6'd0 : {1'b1, t[6:2]}};
    endfunction
    logic [10:0] da, db, dc;
    logic [11:0] sp;
    logic [39:0] prod, add, sum, mag, fr;
    logic [47:0] w;
    logic [7:0]  rb;
    logic [6:0]  r7, mg;
    logic        up, nar;
    int          ps, cs, ld, e, rl;
    // Exact sum on a 2^-22 fixed-point grid, then one rounding back into posit encoding
    always_comb begin
        da   = dec(in_a);
        db   = dec(in_b);
        dc   = dec(in_c);
        sp   = 12'(da[5:0] * db[5:0]);
        ps   = 12 + int'($signed(da[9:6])) + int'($signed(db[9:6]));
        cs   = 17 + int'($signed(dc[9:6]));
        prod = (ps < 0) ? '0 : 40'(sp) << ps;
        add  = 40'(dc[5:0]) << cs;
        sum  = ((da[10] ^ db[10]) ? -prod : prod) + (dc[10] ? -add : add);
        mag  = sum[39] ? -sum : sum;
        ld   = 0;
        for (int i = 0; i < 40; i++) if (mag[i]) ld = i;
        e    = ld - 22;
        rb   = e >= 0 ? 8'(((1 << (e + 1)) - 1) << 1) : 8'd1;
        rl   = e >= 0 ? e + 2 : 1 - e;
        fr   = mag << (40 - ld);
        w    = ({40'd0, rb} << (48 - rl)) | ({fr, 8'd0} >> rl);
        up   = w[40] & ((|w[39:0]) | w[41]);
        r7   = w[47:41] + {6'd0, up};
        mg   = e > 5 ? 7'h7F : e < -6 ? 7'h01 : r7;
        nar  = in_a == POSIT_NAR || in_b == POSIT_NAR || in_c == POSIT_NAR;
        res  = nar ? POSIT_NAR : mag == '0 ? POSIT_ZERO : sum[39] ? 8'(-{1'b0, mg}) : {1'b0, mg};
    end
endmodule

// File: rtl/posit_dot_sequencer.sv
// posit_dot_sequencer: runs one posit MAC through an N-term dot product per command
module posit_dot_sequencer
    import posit_pkg::*;
#(
    parameter int LEN_W = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       cmd_init,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_a,
    input  logic [7:0]       op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic             res_nar,
    output logic             busy,
    output logic [LEN_W-1:0] term_cnt
);
    state_t           state, state_nx;
    logic [7:0]       acc, mac_out;
    logic [LEN_W-1:0] len;
    logic             last;
    posit_mac_8bit u_mac (.in_a(op_a), .in_b(op_b), .in_c(acc), .res(mac_out));
    assign last      = term_cnt == len - LEN_W'(1);
    assign cmd_ready = state == IDLE;
    assign op_ready  = state == RUN;
    assign res_valid = state == DONE;
    assign busy      = state != IDLE;
    assign res_data  = acc;
    // State register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end
    // Next state: zero-length commands skip straight to the result
    always_comb begin
        state_nx = state == IDLE ? (cmd_valid ? (cmd_len != '0 ? RUN : DONE) : IDLE)
                 : state == RUN  ? (op_valid && last ? DONE : RUN)
                 : (res_ready ? IDLE : DONE);
    end
    // Accumulator, term counter and sticky NaR; a NaR accumulator stays NaR for the command
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= POSIT_ZERO;
            len      <= '0;
            term_cnt <= '0;
            res_nar  <= 1'b0;
        end else if (cmd_valid && cmd_ready) begin
            acc      <= cmd_init;
            len      <= cmd_len;
            term_cnt <= '0;
            res_nar  <= cmd_init == POSIT_NAR;
        end else if (op_valid && op_ready) begin
            acc      <= acc == POSIT_NAR ? POSIT_NAR : mac_out;
            term_cnt <= term_cnt + LEN_W'(1);
            res_nar  <= res_nar | (acc == POSIT_NAR) | (mac_out == POSIT_NAR);
        end
    end
endmodule

// File: tb/tb_posit_dot_sequencer.sv
// tb_posit_dot_sequencer: directed and randomized checks against a real-valued posit model
module tb_posit_dot_sequencer;
    logic       clk = 0, rst = 1, cmd_valid = 0, op_valid = 0, res_ready = 0;
    logic [7:0] cmd_len = 0, cmd_init = 0, op_a = 0, op_b = 0;
    logic       cmd_ready, op_ready, res_valid, res_nar, busy;
    logic [7:0] res_data, term_cnt;
    int         checks = 0, errors = 0;
    real        pv[256];
    logic [7:0] qa[$], qb[$];

    posit_dot_sequencer #(.LEN_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_init(cmd_init), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_nar(res_nar), .busy(busy), .term_cnt(term_cnt)
    );

    always #5 clk = ~clk;

    function automatic real p2r(input logic [7:0] p);
        int i, run, k, n;
        real f;
        logic b;
        if (p == 8'h00 || p == 8'h80) return 0.0;
        if (p[7]) return -p2r(8'(-p));
        i = 6; run = 0; b = p[6];
        while (i >= 0 && p[i] == b) begin run++; i--; end
        k = b ? run - 1 : -run;
        i--;
        f = 0.0; n = 0;
        while (i >= 0) begin f = f * 2.0 + (p[i] ? 1.0 : 0.0); n++; i--; end
        return $pow(2.0, k) * (1.0 + f / $pow(2.0, n));
    endfunction

    function automatic logic [7:0] r2p(input real x);
        real ax, d, bd;
        logic [7:0] best;
        if (x == 0.0) return 8'h00;
        ax = x < 0.0 ? -x : x;
        if (ax >= 64.0) return x < 0.0 ? 8'h81 : 8'h7F;
        if (ax <= 1.0 / 64.0) return x < 0.0 ? 8'hFF : 8'h01;
        best = 8'h01; bd = 1.0e9;
        for (int p = 1; p < 256; p++) begin
            if (p == 128) continue;
            d = pv[p] - x;
            if (d < 0.0) d = -d;
            if (d < bd || (d == bd && p % 2 == 0)) begin bd = d; best = 8'(p); end
        end
        return best;
    endfunction

    function automatic logic [7:0] mac_ref(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        if (a == 8'h80 || b == 8'h80 || c == 8'h80) return 8'h80;
        return r2p(pv[a] * pv[b] + pv[c]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one command using the pairs queued in qa/qb, with gaps between pairs and a result stall
    task automatic do_cmd(input string tag, input logic [7:0] init, input int gmin, input int gmax, input int stall);
        int n;
        logic [7:0] ea;
        logic en;
        n = qa.size();
        ea = init;
        en = init == 8'h80;
        for (int i = 0; i < n; i++) begin
            ea = ea == 8'h80 ? 8'h80 : mac_ref(qa[i], qb[i], ea);
            en = en | (ea == 8'h80);
        end
        chk({tag, ".cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1; cmd_len = 8'(n); cmd_init = init;
        step();
        cmd_valid = 0;
        chk({tag, ".busy"}, busy, 1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gmax, gmin)) step();
            chk({tag, ".term_cnt"}, term_cnt, i);
            chk({tag, ".op_ready"}, op_ready, 1);
            op_valid = 1; op_a = qa[i]; op_b = qb[i];
            step();
            op_valid = 0;
        end
        chk({tag, ".res_valid"}, res_valid, 1);
        chk({tag, ".op_ready_done"}, op_ready, 0);
        chk({tag, ".res_data"}, res_data, ea);
        chk({tag, ".res_nar"}, res_nar, en);
        chk({tag, ".term_final"}, term_cnt, n);
        repeat (stall) step();
        chk({tag, ".res_hold"}, res_data, ea);
        res_ready = 1;
        step();
        res_ready = 0;
        chk({tag, ".res_valid_after"}, res_valid, 0);
        chk({tag, ".idle"}, busy, 0);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) pv[i] = p2r(8'(i));
        step(); step();
        rst = 0;
        chk("reset.cmd_ready", cmd_ready, 1);
        chk("reset.op_ready", op_ready, 0);
        chk("reset.res_valid", res_valid, 0);
        chk("reset.busy", busy, 0);
        chk("reset.term_cnt", term_cnt, 0);
        chk("reset.res_data", res_data, 8'h00);
        chk("reset.res_nar", res_nar, 0);
        // three back-to-back 1*1 terms
        qa = '{8'h40, 8'h40, 8'h40}; qb = '{8'h40, 8'h40, 8'h40};
        do_cmd("t1", 8'h00, 0, 0, 0);
        chk("t1.sum3", mac_ref(8'h40, 8'h40, mac_ref(8'h40, 8'h40, 8'h40)), 8'h68);
        // zero-length command
        do_cmd("t2", 8'h40, 0, 0, 0);
        // gapped pairs, 2 + 2*0.5 - 1
        qa = '{8'h60, 8'hC0}; qb = '{8'h20, 8'h40};
        do_cmd("t3", 8'h60, 3, 3, 0);
        // NaR sticks, then clears on the next command
        qa = '{8'h80, 8'h40}; qb = '{8'h40, 8'h40};
        do_cmd("t4", 8'h00, 0, 0, 0);
        do_cmd("t4.clear", 8'h00, 0, 0, 0);
        // result held under backpressure while a command is offered
        qa = '{8'h40}; qb = '{8'h40};
        cmd_valid = 1; cmd_len = 1; cmd_init = 8'h00;
        step();
        cmd_valid = 0;
        op_valid = 1; op_a = 8'h40; op_b = 8'h40;
        step();
        op_valid = 0;
        cmd_valid = 1; cmd_len = 0; cmd_init = 8'h48;
        for (int i = 0; i < 5; i++) begin
            chk("t5.res_valid", res_valid, 1);
            chk("t5.cmd_ready", cmd_ready, 0);
            chk("t5.res_data", res_data, 8'h40);
            step();
        end
        res_ready = 1;
        step();
        res_ready = 0;
        chk("t5.cmd_ready_after", cmd_ready, 1);
        step();
        cmd_valid = 0;
        chk("t5.next_taken", res_valid, 1);
        chk("t5.next_data", res_data, 8'h48);
        res_ready = 1;
        step();
        res_ready = 0;
        qa.delete(); qb.delete();
        // reset abandons a command mid-stream
        cmd_valid = 1; cmd_len = 4; cmd_init = 8'h48;
        step();
        cmd_valid = 0;
        op_valid = 1; op_a = 8'h50; op_b = 8'h50;
        step();
        op_valid = 0;
        rst = 1;
        step();
        rst = 0;
        chk("t6.cmd_ready", cmd_ready, 1);
        chk("t6.busy", busy, 0);
        chk("t6.res_valid", res_valid, 0);
        chk("t6.term_cnt", term_cnt, 0);
        chk("t6.res_data", res_data, 8'h00);
        qa = '{8'h70}; qb = '{8'h40};
        do_cmd("t6.fresh", 8'h00, 0, 0, 0);
        // randomized commands
        for (int c = 0; c < 30; c++) begin
            int n;
            n = $urandom_range(6, 0);
            for (int i = 0; i < n; i++) begin
                qa.push_back(8'($urandom_range(255, 0)));
                qb.push_back(8'($urandom_range(255, 0)));
            end
            do_cmd("rnd", 8'($urandom_range(255, 0)), 0, 2, $urandom_range(3, 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
